// File: rtl/clk_ratio_meter_pkg.sv
// Shared definitions for the clock ratio meter and the VGA timing blocks.
//   - meter_state_t : measurement FSM state encoding
//   - *_DEF         : default widths / lock depth / synchroniser depth
package clk_ratio_meter_pkg;

    localparam int CNT_W_DEF       = 16;
    localparam int LOCK_COUNT_DEF  = 4;
    localparam int SYNC_STAGES_DEF = 2;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_MEASURE = 2'd1,
        ST_TRACK   = 2'd2
    } meter_state_t;

endpackage

// File: rtl/sync_edge_det.sv
// Synchroniser plus edge detector for one asynchronous input.
// Ports:
//   clk_i    : sampling clock
//   reset    : synchronous, active-low reset
//   async_i  : asynchronous input level
//   level_o  : synchronised level (last sync stage)
//   rise_o   : one-cycle pulse per rising edge of the synchronised level
//   fall_o   : one-cycle pulse per falling edge of the synchronised level
// Strobes are registered, so they appear SYNC_STAGES+1 edges after the
// input changes and are glitch-free for downstream consumers.
module sync_edge_det #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic reset,
    input  logic async_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   edge_q;
    logic                   s;

    assign s       = sync_q[SYNC_STAGES-1];
    assign level_o = s;

    always_ff @(posedge clk_i) begin
        if (!reset) begin
            sync_q <= '0;
            edge_q <= 1'b0;
            rise_o <= 1'b0;
            fall_o <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
            edge_q <= s;
            rise_o <= s & ~edge_q;
            fall_o <= ~s & edge_q;
        end
    end

endmodule

// File: rtl/clk_ratio_meter.sv
// Measures a divided clock in the fast clock domain.
// Ports:
//   clk_i     : fast system clock
//   reset     : synchronous, active-low reset
//   div_clk_i : divided clock under measurement (asynchronous)
//   rise_o    : one-cycle pulse per detected rising edge of div_clk_i
//   fall_o    : one-cycle pulse per detected falling edge of div_clk_i
//   period_o  : last rise-to-rise period in clk_i cycles
//   high_o    : last rise-to-fall high time in clk_i cycles
//   locked_o  : period stable for LOCK_COUNT consecutive measurements
//   timeout_o : no rise for 2^CNT_W-1 cycles; held until the next rise
module clk_ratio_meter
    import clk_ratio_meter_pkg::*;
#(
    parameter int CNT_W       = CNT_W_DEF,
    parameter int LOCK_COUNT  = LOCK_COUNT_DEF,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic             clk_i,
    input  logic             reset,
    input  logic             div_clk_i,
    output logic             rise_o,
    output logic             fall_o,
    output logic [CNT_W-1:0] period_o,
    output logic [CNT_W-1:0] high_o,
    output logic             locked_o,
    output logic             timeout_o
);

    localparam int            MW        = $clog2(LOCK_COUNT + 1);
    localparam logic [MW-1:0] LOCK_MAX  = MW'(LOCK_COUNT);
    localparam logic [MW-1:0] LOCK_LAST = MW'(LOCK_COUNT - 1);

    meter_state_t     state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_p1;
    logic [MW-1:0]    match_cnt;

    sync_edge_det #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk_i  (clk_i),
        .reset  (reset),
        .async_i(div_clk_i),
        .level_o(),
        .rise_o (rise_o),
        .fall_o (fall_o)
    );

    // cnt is cleared on the rise cycle, so the edge being measured is
    // counted as cnt+1 (truncated to CNT_W bits).
    assign cnt_p1 = cnt + 1'b1;

    always_ff @(posedge clk_i) begin
        if (!reset) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            match_cnt <= '0;
            period_o  <= '0;
            high_o    <= '0;
            locked_o  <= 1'b0;
            timeout_o <= 1'b0;
        end else begin
            if (rise_o)
                cnt <= '0;
            else if (cnt != '1)
                cnt <= cnt_p1;

            case (state)
                ST_IDLE: begin
                    if (rise_o) begin
                        state     <= ST_MEASURE;
                        timeout_o <= 1'b0;
                    end
                end
                ST_MEASURE: begin
                    if (rise_o) begin
                        period_o  <= cnt_p1;
                        match_cnt <= '0;
                        state     <= ST_TRACK;
                    end else if (fall_o) begin
                        high_o <= cnt_p1;
                    end
                end
                ST_TRACK: begin
                    if (rise_o) begin
                        if (cnt_p1 == period_o) begin
                            if (match_cnt != LOCK_MAX)
                                match_cnt <= match_cnt + 1'b1;
                            // lock on the edge that completes the run
                            if (match_cnt >= LOCK_LAST)
                                locked_o <= 1'b1;
                        end else begin
                            period_o  <= cnt_p1;
                            match_cnt <= '0;
                            locked_o  <= 1'b0;
                        end
                    end else if (fall_o) begin
                        high_o <= cnt_p1;
                    end
                end
                default: state <= ST_IDLE;
            endcase

            // Saturated counter with no rise: the divided clock is gone.
            // A rise on the saturation cycle is a valid edge and wins.
            if (state != ST_IDLE && !rise_o && cnt == '1) begin
                state     <= ST_IDLE;
                locked_o  <= 1'b0;
                match_cnt <= '0;
                timeout_o <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_clk_ratio_meter.sv
module tb_clk_ratio_meter;

    localparam int CNT_W = 4;
    localparam int HMAX  = 64;

    logic             clk_i = 1'b0;
    logic             reset;
    logic             div_clk_i;
    logic             rise_o, fall_o, locked_o, timeout_o;
    logic [CNT_W-1:0] period_o, high_o;

    int n_cmp = 0;
    int n_err = 0;

    // per-cycle history of the last drive_phase call, sampled on negedge
    logic             rise_h [HMAX];
    logic             fall_h [HMAX];
    logic             lock_h [HMAX];
    logic             to_h   [HMAX];
    logic [CNT_W-1:0] per_h  [HMAX];
    logic [CNT_W-1:0] high_h [HMAX];

    clk_ratio_meter #(
        .CNT_W      (CNT_W),
        .LOCK_COUNT (4),
        .SYNC_STAGES(2)
    ) dut (
        .clk_i    (clk_i),
        .reset    (reset),
        .div_clk_i(div_clk_i),
        .rise_o   (rise_o),
        .fall_o   (fall_o),
        .period_o (period_o),
        .high_o   (high_o),
        .locked_o (locked_o),
        .timeout_o(timeout_o)
    );

    always #5 clk_i = ~clk_i;

    // Drive nper periods of (hi cycles high, lo cycles low). Index i is the
    // negedge on which pattern bit i is driven; history[i] is sampled first.
    task automatic drive_phase(input int hi, input int lo, input int nper);
        int n = 0;
        for (int p = 0; p < nper; p++) begin
            for (int c = 0; c < hi + lo; c++) begin
                @(negedge clk_i);
                if (n < HMAX) begin
                    rise_h[n] = rise_o;
                    fall_h[n] = fall_o;
                    lock_h[n] = locked_o;
                    to_h[n]   = timeout_o;
                    per_h[n]  = period_o;
                    high_h[n] = high_o;
                end
                div_clk_i = (c < hi);
                n++;
            end
        end
    endtask

    task automatic test_reset();
        logic [11:0] outs;
        reset     = 1'b0;
        div_clk_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk_i);
            outs = {rise_o, fall_o, period_o, high_o, locked_o, timeout_o};
            n_cmp++;
            if (outs !== 12'd0) begin
                $display("FAIL reset_hold[%0d]: got %h want 000", k, outs);
                n_err++;
            end
            div_clk_i = ~div_clk_i;
        end
        reset     = 1'b1;
        div_clk_i = 1'b0;
        drive_phase(0, 6, 1);
        outs = {rise_h[5], fall_h[5], per_h[5], high_h[5], lock_h[5], to_h[5]};
        n_cmp++;
        if (outs !== 12'd0) begin
            $display("FAIL reset_idle: got %h want 000", outs);
            n_err++;
        end
    endtask

    task automatic test_div4();
        int r = 0;
        drive_phase(2, 2, 7);
        for (int i = 0; i < 28; i++) if (rise_h[i] === 1'b1) r++;
        n_cmp++;
        if (r != 7) begin $display("FAIL div4_rise_count: got %0d want 7", r); n_err++; end
        n_cmp++;
        if ({rise_h[2], rise_h[3], rise_h[4]} !== 3'b010) begin
            $display("FAIL div4_rise_latency: got %b want 010", {rise_h[2], rise_h[3], rise_h[4]});
            n_err++;
        end
        n_cmp++;
        if (fall_h[5] !== 1'b1) begin $display("FAIL div4_fall_latency: got %b want 1", fall_h[5]); n_err++; end
        n_cmp++;
        if (per_h[8] !== 4'd4) begin $display("FAIL div4_first_period: got %0d want 4", per_h[8]); n_err++; end
        n_cmp++;
        if (lock_h[20] !== 1'b0) begin $display("FAIL div4_lock_early: got %b want 0", lock_h[20]); n_err++; end
        n_cmp++;
        if (lock_h[24] !== 1'b1) begin $display("FAIL div4_lock_rise6: got %b want 1", lock_h[24]); n_err++; end
        n_cmp++;
        if ({per_h[27], high_h[27]} !== {4'd4, 4'd2}) begin
            $display("FAIL div4_period_high: got %0d/%0d want 4/2", per_h[27], high_h[27]);
            n_err++;
        end
    endtask

    task automatic test_ratio_change();
        drive_phase(4, 4, 6);
        n_cmp++;
        if ({lock_h[11], per_h[11]} !== {1'b1, 4'd4}) begin
            $display("FAIL ratio_before: got lock=%b per=%0d want 1/4", lock_h[11], per_h[11]);
            n_err++;
        end
        n_cmp++;
        if ({lock_h[12], per_h[12]} !== {1'b0, 4'd8}) begin
            $display("FAIL ratio_switch: got lock=%b per=%0d want 0/8", lock_h[12], per_h[12]);
            n_err++;
        end
        n_cmp++;
        if ({lock_h[43], lock_h[44]} !== 2'b01) begin
            $display("FAIL ratio_relock: got %b want 01", {lock_h[43], lock_h[44]});
            n_err++;
        end
        n_cmp++;
        if (high_h[47] !== 4'd4) begin $display("FAIL ratio_high: got %0d want 4", high_h[47]); n_err++; end
    endtask

    task automatic test_stall();
        drive_phase(0, 20, 1);
        n_cmp++;
        if ({to_h[11], to_h[12]} !== 2'b01) begin
            $display("FAIL stall_timeout: got %b want 01", {to_h[11], to_h[12]});
            n_err++;
        end
        n_cmp++;
        if ({lock_h[11], lock_h[12]} !== 2'b10) begin
            $display("FAIL stall_unlock: got %b want 10", {lock_h[11], lock_h[12]});
            n_err++;
        end
        n_cmp++;
        if ({per_h[19], high_h[19], to_h[19]} !== {4'd8, 4'd4, 1'b1}) begin
            $display("FAIL stall_hold: got per=%0d high=%0d to=%b want 8/4/1", per_h[19], high_h[19], to_h[19]);
            n_err++;
        end
        // recovery: first rise clears timeout, second captures a new period
        drive_phase(2, 2, 3);
        n_cmp++;
        if ({to_h[3], to_h[4]} !== 2'b10) begin
            $display("FAIL stall_clear: got %b want 10", {to_h[3], to_h[4]});
            n_err++;
        end
        n_cmp++;
        if ({high_h[5], high_h[6]} !== {4'd4, 4'd2}) begin
            $display("FAIL stall_measure_high: got %0d/%0d want 4/2", high_h[5], high_h[6]);
            n_err++;
        end
        n_cmp++;
        if ({per_h[7], per_h[8], lock_h[8]} !== {4'd8, 4'd4, 1'b0}) begin
            $display("FAIL stall_measure_period: got %0d/%0d lock=%b want 8/4/0", per_h[7], per_h[8], lock_h[8]);
            n_err++;
        end
    endtask

    task automatic test_mid_reset();
        logic [11:0] outs;
        @(negedge clk_i);
        n_cmp++;
        if (period_o !== 4'd4) begin $display("FAIL midrst_pre: got %0d want 4", period_o); n_err++; end
        reset     = 1'b0;
        div_clk_i = 1'b0;
        @(negedge clk_i);
        outs = {rise_o, fall_o, period_o, high_o, locked_o, timeout_o};
        n_cmp++;
        if (outs !== 12'd0) begin $display("FAIL midrst_clear: got %h want 000", outs); n_err++; end
        reset = 1'b1;
        drive_phase(2, 2, 7);
        n_cmp++;
        if ({per_h[7], per_h[8]} !== {4'd0, 4'd4}) begin
            $display("FAIL midrst_remeasure: got %0d/%0d want 0/4", per_h[7], per_h[8]);
            n_err++;
        end
        n_cmp++;
        if ({lock_h[20], lock_h[24]} !== 2'b01) begin
            $display("FAIL midrst_relock: got %b want 01", {lock_h[20], lock_h[24]});
            n_err++;
        end
    endtask

    task automatic test_asym_duty();
        drive_phase(3, 5, 7);
        n_cmp++;
        if ({lock_h[12], per_h[12]} !== {1'b0, 4'd8}) begin
            $display("FAIL asym_switch: got lock=%b per=%0d want 0/8", lock_h[12], per_h[12]);
            n_err++;
        end
        n_cmp++;
        if ({lock_h[43], lock_h[44]} !== 2'b01) begin
            $display("FAIL asym_lock: got %b want 01", {lock_h[43], lock_h[44]});
            n_err++;
        end
        n_cmp++;
        if ({per_h[55], high_h[55], lock_h[55], to_h[55]} !== {4'd8, 4'd3, 1'b1, 1'b0}) begin
            $display("FAIL asym_final: got per=%0d high=%0d lock=%b to=%b want 8/3/1/0",
                     per_h[55], high_h[55], lock_h[55], to_h[55]);
            n_err++;
        end
    endtask

    initial begin
        test_reset();
        test_div4();
        test_ratio_change();
        test_stall();
        test_mid_reset();
        test_asym_duty();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
